booth_mult_ctrl: RTL and testbench

FSM controller that sequences the 16-bit radix-2 Booth sequential-multiplier datapath (multiplicand/multiplier/accumulator registers, Booth ALU, arithmetic-shift path, iteration counter).
- Upstream side: valid/ready operand handshake. Downstream side: valid/ready result handshake.
- Drives every datapath enable, mux select, ALU op and clear, and consumes count_done, Q0 and Q_1.
- Sits between the multiplier wrapper's request interface and the datapath instance.

---
 rtl/booth_mult_ctrl_pkg.sv | 16 +
 rtl/booth_mult_ctrl_op_decode.sv | 17 +
 rtl/booth_mult_ctrl.sv | 138 +++++++++++++
 tb/tb_booth_mult_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_ctrl_pkg.sv
// Shared types and constants for the Booth multiplier controller.
package booth_ctrl_pkg;
  localparam int WIDTH_M_DEF = 16;
  localparam int CNT_W_DEF   = 5;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_e;
endpackage

// File: rtl/booth_mult_ctrl_op_decode.sv
// Booth pair decode: {Q0,Q_1} selects add, subtract or pass for the ALU.
module booth_op_decode
  import booth_ctrl_pkg::*;
(
  input  logic       i_q0,
  input  logic       i_q_1,
  output logic [1:0] o_alu_op
);
  // 01 -> add M, 10 -> subtract M, 00/11 -> pass A
  always_comb begin
    unique case ({i_q0, i_q_1})
      2'b01:   o_alu_op = ALU_ADD;
      2'b10:   o_alu_op = ALU_SUB;
      default: o_alu_op = ALU_PASS;
    endcase
  end
endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequencer for the radix-2 Booth sequential-multiplier datapath.
// Optional macro BOOTH_CTRL_TIMEOUT_EN adds a CALC watchdog and the err port.
module booth_mult_ctrl
  import booth_ctrl_pkg::*;
#(
  parameter int WIDTH_M = WIDTH_M_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  input  logic       count_done,
  input  logic       Q0,
  input  logic       Q_1,
  output logic       en_multr,
  output logic       en_mltd,
  output logic       en_count,
  output logic       en_ac,
  output logic [1:0] alu_op,
  output logic       selQ,
  output logic       selA,
  output logic       selQ_1,
  output logic       en_out,
  output logic       clear
`ifdef BOOTH_CTRL_TIMEOUT_EN
  , output logic     err
`endif
);

  // The watchdog must be able to reach WIDTH_M+1.
  if (2**CNT_W <= WIDTH_M + 1) begin : g_bad_cnt_w
    $error("CNT_W too narrow for WIDTH_M");
  end

  state_e     r_state;
  state_e     w_next;
  logic [1:0] w_op;
  logic       w_stop;   // iterations finished (or abandoned) this cycle

  booth_op_decode u_dec (
    .i_q0     (Q0),
    .i_q_1    (Q_1),
    .o_alu_op (w_op)
  );

`ifdef BOOTH_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] r_tcnt;
  logic             r_err;
  logic             w_tmo;

  // Give up on the datapath after WIDTH_M+2 CALC cycles without count_done.
  assign w_tmo  = (r_state == CALC) && !count_done && (r_tcnt == CNT_W'(WIDTH_M + 1));
  assign w_stop = count_done | w_tmo;
  assign err    = r_err;

  // Count CALC cycles; restart on every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_tcnt <= '0;
    else if (r_state == IDLE && in_valid) r_tcnt <= '0;
    else if (r_state == CALC && !w_stop)  r_tcnt <= r_tcnt + 1'b1;
  end

  // err rides along with the result and drops once the flush happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_err <= 1'b0;
    else if (w_tmo)              r_err <= 1'b1;
    else if (r_state == FLUSH)   r_err <= 1'b0;
  end
`else
  assign w_stop = count_done;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (in_valid)  w_next = CALC;
      CALC:  if (w_stop)    w_next = DONE;
      DONE:  if (out_ready) w_next = FLUSH;
      FLUSH:                w_next = IDLE;
      default:              w_next = IDLE;
    endcase
  end

  // Output decode; load enables in IDLE and iteration enables in CALC are Mealy.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (r_state != IDLE);
    en_multr  = 1'b0;
    en_mltd   = 1'b0;
    en_count  = 1'b0;
    en_ac     = 1'b0;
    alu_op    = ALU_PASS;
    selQ      = 1'b0;
    selA      = 1'b0;
    selQ_1    = 1'b0;
    en_out    = 1'b1;
    clear     = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          en_mltd  = 1'b1;
          en_multr = 1'b1;
          en_ac    = 1'b1;
        end
      end
      CALC: begin
        if (!w_stop) begin
          en_ac    = 1'b1;
          en_multr = 1'b1;
          en_count = 1'b1;
          selA     = 1'b1;
          selQ     = 1'b1;
          selQ_1   = 1'b1;
          alu_op   = w_op;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        en_out    = 1'b0;
      end
      FLUSH: clear = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Bench for booth_mult_ctrl with a behavioural Booth datapath and a product scoreboard.
module tb_booth_mult_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic in_valid = 1'b0, out_ready = 1'b0, force_cd = 1'b0;
  logic in_ready, out_valid, busy, count_done, Q0, Q_1;
  logic en_multr, en_mltd, en_count, en_ac, selQ, selA, selQ_1, en_out, clear;
  logic [1:0] alu_op;
`ifdef BOOTH_CTRL_TIMEOUT_EN
  logic err;
`endif

  booth_mult_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .count_done(count_done), .Q0(Q0), .Q_1(Q_1),
    .en_multr(en_multr), .en_mltd(en_mltd), .en_count(en_count), .en_ac(en_ac),
    .alu_op(alu_op), .selQ(selQ), .selA(selA), .selQ_1(selQ_1),
    .en_out(en_out), .clear(clear)
`ifdef BOOTH_CTRL_TIMEOUT_EN
    , .err(err)
`endif
  );

  // ---------------- datapath model ----------------
  logic [W-1:0]   mplier = '0, mcand = '0;
  logic [W-1:0]   r_a, r_q, r_m, w_alu;
  logic           r_q1;
  logic [4:0]     r_cnt;
  logic [2*W-1:0] product;

  always_comb begin
    w_alu = r_a;
    if (alu_op == 2'b01)      w_alu = r_a + r_m;
    else if (alu_op == 2'b10) w_alu = r_a - r_m;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0; r_q <= '0; r_m <= '0; r_q1 <= 1'b0; r_cnt <= '0;
    end else if (clear) begin
      r_a <= '0; r_q <= '0; r_m <= '0; r_q1 <= 1'b0; r_cnt <= '0;
    end else begin
      if (en_mltd) r_m <= mcand;
      if (en_ac)   r_a <= selA ? {w_alu[W-1], w_alu[W-1:1]} : '0;
      if (en_multr) begin
        r_q  <= selQ ? {w_alu[0], r_q[W-1:1]} : mplier;
        r_q1 <= selQ_1 ? r_q[0] : 1'b0;
      end
      if (en_count) r_cnt <= r_cnt + 5'd1;
    end
  end

  assign count_done = (r_cnt == 5'(W)) && !force_cd;
  assign Q0         = r_q[0];
  assign Q_1        = r_q1;
  assign product    = en_out ? '0 : {r_a, r_q};

  // ---------------- checking ----------------
  int n_chk = 0, n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic any_en();
    return en_multr | en_mltd | en_count | en_ac | selQ | selA | selQ_1 | (alu_op != 2'b00);
  endfunction

  // One full transaction; hold = cycles out_ready stays low in DONE.
  task automatic run_op(input logic [W-1:0] mq, input logic [W-1:0] mm, input int hold);
    int cyc, ncnt, mism;
    logic [1:0] first_op, exp_op;
    logic bad;
    int p;
    mplier = mq; mcand = mm; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("acc_ready", in_ready, 1'b1);
    chk("acc_load", {en_mltd, en_multr, en_ac, selQ, selA}, 5'b11100);
    if (in_valid && in_ready) begin
      p = int'($signed(mq)) * int'($signed(mm));
      exp_q.push_back(32'(p));
    end
    tick();
    in_valid = 1'b0; mplier = '0; mcand = '0;
    cyc = 1; ncnt = 0; mism = 0; first_op = 2'b11;
    while (!out_valid && cyc < 40) begin
      if (en_count) begin
        ncnt++;
        exp_op = ({Q0, Q_1} == 2'b01) ? 2'b01 : ({Q0, Q_1} == 2'b10) ? 2'b10 : 2'b00;
        if (alu_op !== exp_op) mism++;
        if (cyc == 1) first_op = alu_op;
      end
      if (!busy || in_ready) mism++;
      tick(); cyc++;
    end
    chk("latency", cyc, 18);
    chk("iters", ncnt, 16);
    chk("op_seq", mism, 0);
    chk("first_op", first_op, mq[0] ? 2'b10 : 2'b00);
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bad |= !out_valid | en_out | any_en() | clear | in_ready;
      tick();
    end
    chk("done_hold", bad, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("done_valid", out_valid, 1'b1);
`ifdef BOOTH_CTRL_TIMEOUT_EN
    chk("no_err", err, 1'b0);
`endif
    if (exp_q.size() == 0) chk("sb_empty", 1'b1, 1'b0);
    else                   chk("product", product, exp_q.pop_front());
    tick();
    out_ready = 1'b0;
    chk("flush_clear", clear, 1'b1);
    chk("flush_rdy", in_ready, 1'b0);
    tick();
    chk("clear_once", clear, 1'b0);
    chk("idle_rdy", in_ready, 1'b1);
  endtask

  initial begin
    logic bad;
    int n;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_outs", {any_en(), clear, en_out}, 3'b001);
    rst_n = 1'b1;
    // idle with no stimulus
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      bad |= !in_ready | busy | !en_out | clear | any_en() | out_valid | (product != '0);
    end
    chk("idle_quiet", bad, 1'b0);

    run_op(16'h0003, 16'h0005, 0);
    run_op(16'hFFFF, 16'h0002, 0);
    run_op(16'h1234, 16'hFFF3, 5);

    // reset in the middle of CALC
    mplier = 16'h0003; mcand = 16'h0005; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rdy", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      bad |= out_valid | busy;
    end
    chk("rst_no_valid", bad, 1'b0);
    run_op(16'h0007, 16'h0007, 0);

`ifdef BOOTH_CTRL_TIMEOUT_EN
    force_cd = 1'b1;
    mplier = 16'h0003; mcand = 16'h0005; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      if (busy) n++;
      tick();
    end
    chk("tmo_calc", n, 18);
    chk("tmo_valid", out_valid, 1'b1);
    chk("tmo_err", err, 1'b1);
    chk("tmo_no_en", any_en(), 1'b0);
    force_cd = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("tmo_err_clr", err, 1'b0);
    chk("tmo_idle", in_ready, 1'b1);
`else
    n = 0;
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
